quad_bus_arbiter: RTL
=====================

Name: quad_bus_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 4-bit output bus between sources A and B.
- Drives the select of a quad 2:1 mux; the mux passes data_a when s=1 and data_b when s=0.
- Grants are held while the owner keeps requesting, with a bounded burst when the other side is waiting.
- Sits between two 4-bit producers and a single shared consumer.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles while the other requester waits; legal range 2..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clock  input  1  rising-edge clock.
- reset_b  input  1  asynchronous active-low reset.
- req_a  input  1  request from source A.
- req_b  input  1  request from source B.
- data_a  input  4  source A data.
- data_b  input  4  source B data.
- gnt_a  output  1  registered grant to A.
- gnt_b  output  1  registered grant to B.
- s  output  1  mux select, registered; 1 selects A.
- y  output  4  shared bus: s ? data_a : data_b (combinational through the mux).
- valid  output  1  gnt_a | gnt_b.

Behaviour:
- Reset (reset_b=0, asynchronous, takes effect immediately):
  - state=IDLE, gnt_a=0, gnt_b=0, s=0, hold_cnt=0, last=B, valid=0.
  - y then shows data_b.
  - A reset asserted mid-grant drops the grant immediately; there is no partial-burst memory.
- States: IDLE, GRANT_A, GRANT_B. Outputs decode from registered state: gnt_a/s=1 in GRANT_A; gnt_b=1 in GRANT_B.
- IDLE transitions:
  - req_a & req_b -> grant the side not equal to last. After reset A wins the first tie.
  - req_a only -> GRANT_A. req_b only -> GRANT_B. Neither -> stay in IDLE.
- GRANT_A transitions (GRANT_B symmetric):
  - !req_a & req_b -> GRANT_B.
  - !req_a & !req_b -> IDLE.
  - req_a & req_b & hold_cnt==MAX_HOLD-1 -> GRANT_B (forced rotation).
  - Otherwise stay.
- hold_cnt:
  - Cleared on every state change.
  - Increments each cycle the arbiter stays in a grant state.
  - Saturates at MAX_HOLD-1 when uncontended.
  - Contention arriving after saturation forces a switch at the next edge.
- last: updates to A or B on every entry to GRANT_A or GRANT_B respectively; unchanged in IDLE.
- Latency: a request seen at edge k gives a grant visible after edge k; y valid in the same cycle as the grant.
- Handshake: a requester owns the bus while its gnt=1. Deasserting req releases the bus at the next edge. Data must be held stable while granted.
- Grant exclusivity: gnt_a and gnt_b are never both 1.
- Fairness bound: a continuously requesting side waits at most MAX_HOLD cycles.
- Simultaneous release and request: a direct A->B handoff happens with no IDLE bubble.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, GRANT_A=2'b01, GRANT_B=2'b10.
  - side encodings: SIDE_A=1'b1, SIDE_B=1'b0.
- One sub-module: the existing quad_2X1_mux, instantiated for the y datapath with s from the FSM.
- FSM, counter and last register stay in quad_bus_arbiter.

Test Plan:
- Reset check: reset_b=0 with req_a=req_b=1, data_b=4'b1010 -> gnt_a=gnt_b=0, s=0, valid=0, y=1010; release reset -> GRANT_A after first edge (A wins first tie).
- Single requester: req_a=1 only, data_a=4'b0101, held 10 cycles -> gnt_a=1, s=1, y=0101 throughout, no switch, hold_cnt saturates at 3.
- Contention with MAX_HOLD=4: req_a=req_b=1 continuously -> grant pattern A,A,A,A,B,B,B,B,A…; each gnt level lasts exactly 4 cycles.
- Handoff without bubble: A granted, req_a drops while req_b=1 on the same edge -> next cycle gnt_b=1, s=0, y=data_b, valid never 0.
- Release to idle then tie: A releases with req_b=0 -> IDLE, valid=0; then both request -> B granted (last=A).
- Mid-burst reset: assert reset_b=0 asynchronously during GRANT_B -> gnt_b falls without a clock edge; after release with req_a=req_b=1 -> A granted.

Source files
------------

// File: rtl/quad_bus_arbiter_pkg.sv
// Shared encodings for the two-requester bus arbiter: FSM state codes and
// the side identifiers used by the round-robin "last owner" register.
package quad_bus_arbiter_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GRANT_A = 2'b01;
    localparam logic [1:0] GRANT_B = 2'b10;

    localparam logic SIDE_A = 1'b1;
    localparam logic SIDE_B = 1'b0;

    // On a simultaneous request from idle, the side that did not own the bus last wins.
    function automatic logic [1:0] tie_winner(input logic last_side);
        return (last_side == SIDE_A) ? GRANT_B : GRANT_A;
    endfunction

endpackage

// File: rtl/quad_bus_arbiter_mux.sv
// Quad 2:1 multiplexer: passes a when s=1, b when s=0.
module quad_2X1_mux (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       s,
    output logic [3:0] y
);

    assign y = s ? a : b;

endmodule

// File: rtl/quad_bus_arbiter.sv
// Round-robin arbiter sharing a 4-bit bus between sources A and B, with a
// bounded burst length whenever the other side is waiting.
module quad_bus_arbiter
    import quad_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] data_a,
    input  logic [3:0] data_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       s,
    output logic [3:0] y,
    output logic       valid
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic             last;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && req_b)
                    state_nxt = tie_winner(last);
                else if (req_a)
                    state_nxt = GRANT_A;
                else if (req_b)
                    state_nxt = GRANT_B;
            end
            GRANT_A: begin
                if (!req_a)
                    state_nxt = req_b ? GRANT_B : IDLE;
                else if (req_b && hold_cnt == HOLD_LAST)
                    state_nxt = GRANT_B;
            end
            GRANT_B: begin
                if (!req_b)
                    state_nxt = req_a ? GRANT_A : IDLE;
                else if (req_a && hold_cnt == HOLD_LAST)
                    state_nxt = GRANT_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The counter saturates so that contention arriving late still forces a switch next edge.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= SIDE_B;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                hold_cnt <= '0;
            else if (state != IDLE && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + 1'b1;
            if (state_nxt == GRANT_A && state != GRANT_A)
                last <= SIDE_A;
            else if (state_nxt == GRANT_B && state != GRANT_B)
                last <= SIDE_B;
        end
    end

    assign gnt_a = (state == GRANT_A);
    assign gnt_b = (state == GRANT_B);
    assign s     = gnt_a;
    assign valid = gnt_a | gnt_b;

    quad_2X1_mux u_mux (
        .a (data_a),
        .b (data_b),
        .s (s),
        .y (y)
    );

endmodule
